ex_stage: RTL and testbench

//  Execute stage: ALU, branch/jump target generation and optional iterative RV32M mul/div unit.

---
 rtl/ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump target and registered EX->MEM payload.
// Define EX_MULDIV_EN to build the RV32M multiplier, iterative divider and divide FSM.
module ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_CYCLES = 32,
  parameter int MEM_CTL_W  = 4,
  parameter int WB_CTL_W   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic                    flush_i,
  input  logic [DATA_WIDTH-1:0]   pc_i,
  input  logic [DATA_WIDTH-1:0]   op_a_i,
  input  logic [DATA_WIDTH-1:0]   op_b_i,
  input  logic [DATA_WIDTH-1:0]   imm_i,
  input  logic                    b_sel_imm_i,
  input  logic                    jalr_i,
  input  logic [4:0]              alu_op_i,
  input  logic [4:0]              dest_reg_i,
  input  logic [MEM_CTL_W-1:0]    mem_ctl_i,
  input  logic [WB_CTL_W-1:0]     wb_ctl_i,
  output logic                    stall_o,
  output logic                    valid_o,
  output logic [4*DATA_WIDTH+4:0] mem_pipeline_o,
  output logic [MEM_CTL_W-1:0]    mem_ctl_o,
  output logic [WB_CTL_W-1:0]     wb_ctl_o
);
  localparam int PL_W = 4*DATA_WIDTH+5;

  if (DATA_WIDTH != 32 || DIV_CYCLES != DATA_WIDTH) begin : g_bad_cfg
    $error("ex_stage: only DATA_WIDTH=32 with DIV_CYCLES=DATA_WIDTH is supported");
  end

  logic signed [DATA_WIDTH-1:0] a_s, b_s;
  logic [DATA_WIDTH-1:0] opb, alu_res, branch_addr, jalr_sum, res_sel;
  logic [4:0] shamt;
  logic load;
  logic [MEM_CTL_W-1:0] mem_ctl_sel;
  logic [WB_CTL_W-1:0] wb_ctl_sel;

  assign opb         = b_sel_imm_i ? imm_i : op_b_i;
  assign a_s         = $signed(op_a_i);
  assign b_s         = $signed(opb);
  assign shamt       = opb[4:0];
  assign jalr_sum    = op_a_i + imm_i;
  assign branch_addr = jalr_i ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : (pc_i + imm_i);

`ifdef EX_MULDIV_EN
  // One 66-bit signed multiplier; operand sign-extension selects MULH/MULHSU/MULHU.
  logic mul_sa, mul_sb;
  logic signed [2*DATA_WIDTH+1:0] mul_a, mul_b, mul_p;

  assign mul_sa = (alu_op_i == 5'd17) || (alu_op_i == 5'd18);
  assign mul_sb = (alu_op_i == 5'd17);
  assign mul_a  = $signed({{(DATA_WIDTH+2){mul_sa & op_a_i[DATA_WIDTH-1]}}, op_a_i});
  assign mul_b  = $signed({{(DATA_WIDTH+2){mul_sb & opb[DATA_WIDTH-1]}}, opb});
  assign mul_p  = mul_a * mul_b;
`endif

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      5'd0:  alu_res = op_a_i + opb;
      5'd1:  alu_res = op_a_i - opb;
      5'd2:  alu_res = op_a_i << shamt;
      5'd3:  alu_res = {{(DATA_WIDTH-1){1'b0}}, a_s < b_s};
      5'd4:  alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a_i < opb};
      5'd5:  alu_res = op_a_i ^ opb;
      5'd6:  alu_res = op_a_i >> shamt;
      5'd7:  alu_res = $unsigned(a_s >>> shamt);
      5'd8:  alu_res = op_a_i | opb;
      5'd9:  alu_res = op_a_i & opb;
      5'd10: alu_res = opb;
`ifdef EX_MULDIV_EN
      5'd16: alu_res = mul_p[DATA_WIDTH-1:0];
      5'd17, 5'd18, 5'd19: alu_res = mul_p[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;
  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] quo_q, rem_q, dvsr_q, dvnd_q;
  logic neg_q_q, neg_r_q, is_rem_q;
  logic [MEM_CTL_W-1:0] dmem_ctl_q;
  logic [WB_CTL_W-1:0] dwb_ctl_q;
  logic is_div, div_start, neg_a, neg_b, r_ge;
  logic [DATA_WIDTH:0] r_shift, r_diff;

  // Sign fix-up of the magnitude result plus the RISC-V divide-by-zero results.
  function automatic logic [DATA_WIDTH-1:0] div_fix(
    input logic is_rem, input logic by_zero, input logic neg_q, input logic neg_r,
    input logic [DATA_WIDTH-1:0] quo, input logic [DATA_WIDTH-1:0] rem,
    input logic [DATA_WIDTH-1:0] dvnd);
    if (by_zero) return is_rem ? dvnd : '1;
    if (is_rem) return neg_r ? -rem : rem;
    return neg_q ? -quo : quo;
  endfunction

  assign is_div    = (alu_op_i[4:2] == 3'b101);
  assign div_start = valid_i & is_div & ~flush_i & ~rst_i & (state_q == S_IDLE);
  assign neg_a     = ~alu_op_i[0] & op_a_i[DATA_WIDTH-1];
  assign neg_b     = ~alu_op_i[0] & opb[DATA_WIDTH-1];
  assign r_shift   = {rem_q, quo_q[DATA_WIDTH-1]};
  assign r_ge      = (r_shift >= {1'b0, dvsr_q});
  assign r_diff    = r_shift - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: if (div_start) begin
        state_d = S_BUSY;
        stall_o = 1'b1;
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES-1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i || rst_i) begin
      state_d = S_IDLE;
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (div_start) begin
      cnt_q      <= '0;
      quo_q      <= neg_a ? -op_a_i : op_a_i;
      rem_q      <= '0;
      dvsr_q     <= neg_b ? -opb : opb;
      dvnd_q     <= op_a_i;
      neg_q_q    <= neg_a ^ neg_b;
      neg_r_q    <= neg_a;
      is_rem_q   <= alu_op_i[1];
      dmem_ctl_q <= mem_ctl_i;
      dwb_ctl_q  <= wb_ctl_i;
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= r_ge ? r_diff[DATA_WIDTH-1:0] : r_shift[DATA_WIDTH-1:0];
      quo_q <= {quo_q[DATA_WIDTH-2:0], r_ge};
    end
  end

  assign load        = (valid_i & ~is_div & (state_q == S_IDLE)) | (state_q == S_DONE);
  assign res_sel     = (state_q == S_DONE) ?
                       div_fix(is_rem_q, dvsr_q == '0, neg_q_q, neg_r_q, quo_q, rem_q, dvnd_q) :
                       alu_res;
  assign mem_ctl_sel = (state_q == S_DONE) ? dmem_ctl_q : mem_ctl_i;
  assign wb_ctl_sel  = (state_q == S_DONE) ? dwb_ctl_q : wb_ctl_i;
`else
  assign stall_o     = 1'b0;
  assign load        = valid_i;
  assign res_sel     = alu_res;
  assign mem_ctl_sel = mem_ctl_i;
  assign wb_ctl_sel  = wb_ctl_i;
`endif

  // EX -> MEM boundary
  logic vld_p1;
  logic [PL_W-1:0] pl_p1;
  logic [MEM_CTL_W-1:0] mem_ctl_p1;
  logic [WB_CTL_W-1:0] wb_ctl_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      pl_p1      <= '0;
      mem_ctl_p1 <= '0;
      wb_ctl_p1  <= '0;
    end else if (flush_i) begin
      vld_p1     <= 1'b0;
      mem_ctl_p1 <= '0;
      wb_ctl_p1  <= '0;
    end else begin
      vld_p1     <= load;
      mem_ctl_p1 <= load ? mem_ctl_sel : '0;
      wb_ctl_p1  <= load ? wb_ctl_sel : '0;
      if (load) pl_p1 <= {pc_i, branch_addr, op_b_i, dest_reg_i, res_sel};
    end
  end

  assign valid_o        = vld_p1;
  assign mem_pipeline_o = pl_p1;
  assign mem_ctl_o      = mem_ctl_p1;
  assign wb_ctl_o       = wb_ctl_p1;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branch targets, divide FSM timing, flush and reset.
// Expected values switch on EX_MULDIV_EN so the same bench covers both builds.
module tb_ex_stage;
`ifdef EX_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i, valid_i, flush_i, b_sel_imm_i, jalr_i;
  logic [31:0] pc_i, op_a_i, op_b_i, imm_i;
  logic [4:0] alu_op_i, dest_reg_i;
  logic [3:0] mem_ctl_i, mem_ctl_o;
  logic [2:0] wb_ctl_i, wb_ctl_o;
  logic stall_o, valid_o;
  logic [132:0] mem_pipeline_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .imm_i(imm_i),
    .b_sel_imm_i(b_sel_imm_i), .jalr_i(jalr_i), .alu_op_i(alu_op_i),
    .dest_reg_i(dest_reg_i), .mem_ctl_i(mem_ctl_i), .wb_ctl_i(wb_ctl_i),
    .stall_o(stall_o), .valid_o(valid_o), .mem_pipeline_o(mem_pipeline_o),
    .mem_ctl_o(mem_ctl_o), .wb_ctl_o(wb_ctl_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op_i = op; op_a_i = a; op_b_i = b;
    b_sel_imm_i = 1'b0; jalr_i = 1'b0; imm_i = '0; pc_i = 32'h100; dest_reg_i = 5'd3;
  endtask

  // Issue one instruction, model ID holding it while stall_o is high, and observe
  // latency, stall count and any repeated valid_o. kill_at < 0 means no flush/reset.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int exp_stall, input int kill_at, input bit kill_rst);
    int lat, nstall, extra;
    logic [31:0] res;
    logic [3:0] mctl;
    logic hold;
    lat = -1; nstall = 0; extra = 0; res = '0; mctl = '0;
    set_op(op, a, b);
    valid_i = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0 && valid_o) begin
        if (lat < 0) begin
          lat = c; res = mem_pipeline_o[31:0]; mctl = mem_ctl_o;
        end else extra++;
      end
      if (c == kill_at) begin
        if (kill_rst) rst_i = 1'b1;
        else flush_i = 1'b1;
      end
      #1;
      if (valid_i && stall_o) nstall++;
      hold = valid_i && stall_o;
      @(posedge clk); #1;
      flush_i = 1'b0; rst_i = 1'b0;
      if (!hold) valid_i = 1'b0;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " stall cycles"}, nstall, exp_stall);
    check({tag, " extra valid"}, extra, 0);
    if (exp_lat >= 0) begin
      check({tag, " result"}, res, exp_res);
      check({tag, " mem_ctl"}, mctl, 4'hA);
    end
    check({tag, " idle ctl"}, {mem_ctl_o, wb_ctl_o}, 0);
    if (kill_rst) check({tag, " payload cleared"}, |mem_pipeline_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    mem_ctl_i = 4'hA; wb_ctl_i = 3'h5;
    set_op(5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", valid_o, 0);
    check("reset stall", stall_o, 0);
    check("reset payload", |mem_pipeline_o, 0);
    check("reset ctl", {mem_ctl_o, wb_ctl_o}, 0);
    rst_i = 1'b0;

    // Back-to-back ADD then SUB
    set_op(5'd0, 32'd5, 32'd7); valid_i = 1'b1;
    @(posedge clk); #1;
    check("add result", mem_pipeline_o[31:0], 32'd12);
    check("add valid", valid_o, 1);
    check("add wdata", mem_pipeline_o[68:37], 32'd7);
    check("add dest", mem_pipeline_o[36:32], 5'd3);
    check("add pc", mem_pipeline_o[132:101], 32'h100);
    check("add wb_ctl", wb_ctl_o, 3'h5);
    set_op(5'd1, 32'd3, 32'd5);
    @(posedge clk); #1;
    check("sub result", mem_pipeline_o[31:0], 32'hFFFFFFFE);
    check("sub valid", valid_o, 1);
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("bubble valid", valid_o, 0);
    check("bubble ctl", {mem_ctl_o, wb_ctl_o}, 0);

    // Branch targets
    set_op(5'd0, 32'h1001, 32'd0); b_sel_imm_i = 1'b1; jalr_i = 1'b1; imm_i = 32'd4;
    valid_i = 1'b1;
    @(posedge clk); #1;
    check("jalr target", mem_pipeline_o[100:69], 32'h1004);
    check("add imm", mem_pipeline_o[31:0], 32'h1005);
    set_op(5'd0, 32'd0, 32'd0); pc_i = 32'h200; imm_i = 32'hFFFFFFF8;
    @(posedge clk); #1;
    check("pc rel target", mem_pipeline_o[100:69], 32'h1F8);
    valid_i = 1'b0;
    @(posedge clk); #1;

    run_op("sra",   5'd7,  32'h80000000, 32'd4,  32'hF8000000, 1, 0, -1, 0);
    run_op("srl",   5'd6,  32'h80000000, 32'd4,  32'h08000000, 1, 0, -1, 0);
    run_op("sll",   5'd2,  32'd1,        32'h3F, 32'h80000000, 1, 0, -1, 0);
    run_op("slt",   5'd3,  32'hFFFFFFFF, 32'd1,  32'd1,        1, 0, -1, 0);
    run_op("sltu",  5'd4,  32'hFFFFFFFF, 32'd1,  32'd0,        1, 0, -1, 0);
    run_op("xor",   5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, -1, 0);
    run_op("or",    5'd8,  32'hF0F0F0F0, 32'h0F000001, 32'hFFF0F0F1, 1, 0, -1, 0);
    run_op("and",   5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0, -1, 0);
    run_op("passb", 5'd10, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE, 1, 0, -1, 0);
    run_op("op11",  5'd11, 32'h12345678, 32'hCAFEBABE, 32'd0,        1, 0, -1, 0);
    run_op("op24",  5'd24, 32'h12345678, 32'hCAFEBABE, 32'd0,        1, 0, -1, 0);

    run_op("mul",    5'd16, 32'd3,        32'hFFFFFFFE, MD ? 32'hFFFFFFFA : 32'd0, 1, 0, -1, 0);
    run_op("mulh",   5'd17, 32'h80000000, 32'h80000000, MD ? 32'h40000000 : 32'd0, 1, 0, -1, 0);
    run_op("mulhsu", 5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'hFFFFFFFF : 32'd0, 1, 0, -1, 0);
    run_op("mulhu",  5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'hFFFFFFFE : 32'd0, 1, 0, -1, 0);

    run_op("div 100/7",  5'd20, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("rem 100/7",  5'd22, 32'd100, 32'd7, MD ? 32'd2 : 32'd0,  MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("divu 5/0",   5'd21, 32'd5,   32'd0, MD ? 32'hFFFFFFFF : 32'd0, MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("rem 5/0",    5'd22, 32'd5,   32'd0, MD ? 32'd5 : 32'd0,  MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("div ovf",    5'd20, 32'h80000000, 32'hFFFFFFFF, MD ? 32'h80000000 : 32'd0,
           MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("rem ovf",    5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("div -7/2",   5'd20, 32'hFFFFFFF9, 32'd2, MD ? 32'hFFFFFFFD : 32'd0,
           MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("rem -7/2",   5'd22, 32'hFFFFFFF9, 32'd2, MD ? 32'hFFFFFFFF : 32'd0,
           MD ? 34 : 1, MD ? 33 : 0, -1, 0);
    run_op("remu 7/3",   5'd23, 32'd7, 32'd3, MD ? 32'd1 : 32'd0, MD ? 34 : 1, MD ? 33 : 0, -1, 0);

    run_op("div flushed",   5'd20, 32'd100, 32'd7, 32'd0, MD ? -1 : 1, MD ? 10 : 0, 10, 0);
    run_op("add after flush", 5'd0, 32'd1, 32'd2, 32'd3, 1, 0, -1, 0);
    run_op("div reset",     5'd20, 32'd100, 32'd7, 32'd0, MD ? -1 : 1, MD ? 5 : 0, 5, 1);
    run_op("add after reset", 5'd0, 32'd4, 32'd4, 32'd8, 1, 0, -1, 0);
    run_op("add with flush", 5'd0, 32'd1, 32'd1, 32'd2, -1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
